// File: rtl/dlyreg_tap.sv
// Delay line with a fixed tap and a runtime-selectable tap. A tap-2 delay change
// drains the line first so no sample is ever seen twice or at a stale delay.
module dlyreg_tap #(
    parameter int    DATA_W   = 64,
    parameter int    MAX_DLY  = 16,
    parameter int    OUT1_LOC = 5,
    parameter int    DEF_DLY  = 10,
    parameter string USE_SHR  = "true"
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ce,
    input  logic                           flush,
    input  logic                           valid_i,
    input  logic [DATA_W-1:0]              data_i,
    output logic                           in_rdy_o,
    output logic                           valid1_o,
    output logic [DATA_W-1:0]              data1_o,
    output logic                           valid2_o,
    output logic [DATA_W-1:0]              data2_o,
    input  logic                           cfg_req,
    input  logic [$clog2(MAX_DLY+1)-1:0]   cfg_dly,
    output logic                           cfg_ack_o
);

    localparam int DLY_W    = $clog2(MAX_DLY + 1);
    localparam int OUT1_EFF = (OUT1_LOC > MAX_DLY) ? MAX_DLY : OUT1_LOC;
    localparam int DEF_EFF  = (DEF_DLY > MAX_DLY) ? MAX_DLY : DEF_DLY;

    localparam logic [DLY_W-1:0] MAX_C  = DLY_W'(MAX_DLY);
    localparam logic [DLY_W-1:0] OUT1_C = DLY_W'(OUT1_EFF);
    localparam logic [DLY_W-1:0] DEF_C  = DLY_W'(DEF_EFF);
    localparam logic [DLY_W-1:0] ZERO_C = {DLY_W{1'b0}};
    localparam logic [DLY_W-1:0] ONE_C  = DLY_W'(1);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [DLY_W-1:0]  dly_cur_q, dly_cur_d;
    logic [DLY_W-1:0]  dly_pend_q, dly_pend_d;
    logic [DLY_W-1:0]  cnt_q, cnt_d;
    logic              ack_q, ack_d;
    logic [MAX_DLY:1]  vld_q, vld_d;

    logic              apply_s;
    logic              in_acc_s;
    logic [DLY_W-1:0]  cfg_clamp_s;
    logic [DLY_W-1:0]  drain_ld_s;

    logic [DATA_W-1:0] stage_dat_s [1:MAX_DLY];
    logic              tap_vld_s   [0:MAX_DLY];
    logic [DATA_W-1:0] tap_dat_s   [0:MAX_DLY];

    assign in_rdy_o  = (state_q == ST_RUN);
    assign in_acc_s  = valid_i & in_rdy_o;
    assign cfg_ack_o = ack_q;

    // Clamp the requested delay and size the drain so both taps empty completely.
    always_comb begin
        cfg_clamp_s = (cfg_dly > MAX_C) ? MAX_C : cfg_dly;
        drain_ld_s  = (dly_cur_q > OUT1_C) ? dly_cur_q : OUT1_C;
    end

    // RUN/DRAIN control: accept a request, count down enabled cycles, then apply.
    always_comb begin
        state_d    = state_q;
        dly_cur_d  = dly_cur_q;
        dly_pend_d = dly_pend_q;
        cnt_d      = cnt_q;
        ack_d      = 1'b0;
        apply_s    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (cfg_req && !ack_q) begin
                    dly_pend_d = cfg_clamp_s;
                    cnt_d      = drain_ld_s;
                    state_d    = ST_DRAIN;
                end else begin
                    state_d    = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // A zero count applies immediately, independent of ce.
                if (cnt_q == ZERO_C) begin
                    apply_s   = 1'b1;
                    dly_cur_d = dly_pend_q;
                    ack_d     = 1'b1;
                    state_d   = ST_RUN;
                end else if (flush) begin
                    cnt_d     = ZERO_C;
                end else if (ce) begin
                    cnt_d     = cnt_q - ONE_C;
                end else begin
                    cnt_d     = cnt_q;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = ZERO_C;
            end
        endcase
    end

    // Valid-bit shift chain; flush and delay apply both wipe it, including stage 1.
    always_comb begin
        vld_d = vld_q;
        if (flush || apply_s) begin
            vld_d = {MAX_DLY{1'b0}};
        end else if (ce) begin
            vld_d[1] = in_acc_s;
            for (int k = 2; k <= MAX_DLY; k++) begin
                vld_d[k] = vld_q[k-1];
            end
        end else begin
            vld_d = vld_q;
        end
    end

    // Control and valid state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            dly_cur_q  <= DEF_C;
            dly_pend_q <= DEF_C;
            cnt_q      <= ZERO_C;
            ack_q      <= 1'b0;
            vld_q      <= {MAX_DLY{1'b0}};
        end else begin
            state_q    <= state_d;
            dly_cur_q  <= dly_cur_d;
            dly_pend_q <= dly_pend_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            vld_q      <= vld_d;
        end
    end

    // Data fields carry no reset so the chain can map onto shift-register primitives.
    if (USE_SHR == "false") begin : g_no_shr
        (* shreg_extract = "no" *) logic [DATA_W-1:0] dat_q [1:MAX_DLY];

        // Register-only data chain.
        always_ff @(posedge clk) begin
            if (ce) begin
                dat_q[1] <= data_i;
                for (int k = 2; k <= MAX_DLY; k++) begin
                    dat_q[k] <= dat_q[k-1];
                end
            end
        end

        // Expose stage contents to the tap muxes.
        always_comb begin
            for (int k = 1; k <= MAX_DLY; k++) begin
                stage_dat_s[k] = dat_q[k];
            end
        end
    end else begin : g_shr
        (* shreg_extract = "yes" *) logic [DATA_W-1:0] dat_q [1:MAX_DLY];

        // Data chain eligible for shift-register mapping.
        always_ff @(posedge clk) begin
            if (ce) begin
                dat_q[1] <= data_i;
                for (int k = 2; k <= MAX_DLY; k++) begin
                    dat_q[k] <= dat_q[k-1];
                end
            end
        end

        // Expose stage contents to the tap muxes.
        always_comb begin
            for (int k = 1; k <= MAX_DLY; k++) begin
                stage_dat_s[k] = dat_q[k];
            end
        end
    end

    // Tap table: index 0 is the live input, index k is stage k.
    always_comb begin
        tap_vld_s[0] = in_acc_s & ce;
        tap_dat_s[0] = data_i;
        for (int k = 1; k <= MAX_DLY; k++) begin
            tap_vld_s[k] = vld_q[k];
            tap_dat_s[k] = stage_dat_s[k];
        end
    end

    assign valid1_o = tap_vld_s[OUT1_EFF];
    assign data1_o  = tap_dat_s[OUT1_EFF];
    assign valid2_o = tap_vld_s[dly_cur_q];
    assign data2_o  = tap_dat_s[dly_cur_q];

endmodule

// File: tb/tb_dlyreg_tap.sv
// Scoreboard bench for dlyreg_tap: accepted samples are queued per tap with the
// enabled-cycle count at which they must appear, and checked as the taps fire.
module tb_dlyreg_tap;

    localparam int DW = 64;
    localparam int MD = 16;
    localparam int O1 = 5;
    localparam int DD = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ce;
    logic          flush;
    logic          valid_i;
    logic [DW-1:0] data_i;
    logic          in_rdy_o;
    logic          valid1_o;
    logic [DW-1:0] data1_o;
    logic          valid2_o;
    logic [DW-1:0] data2_o;
    logic          cfg_req;
    logic [4:0]    cfg_dly;
    logic          cfg_ack_o;

    always #5 clk = ~clk;

    dlyreg_tap #(
        .DATA_W(DW), .MAX_DLY(MD), .OUT1_LOC(O1), .DEF_DLY(DD), .USE_SHR("true")
    ) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .flush(flush),
        .valid_i(valid_i), .data_i(data_i), .in_rdy_o(in_rdy_o),
        .valid1_o(valid1_o), .data1_o(data1_o),
        .valid2_o(valid2_o), .data2_o(data2_o),
        .cfg_req(cfg_req), .cfg_dly(cfg_dly), .cfg_ack_o(cfg_ack_o)
    );

    typedef struct {
        logic [DW-1:0] d;
        longint        due;
    } exp_t;

    exp_t   q1[$];
    exp_t   q2[$];
    int     n_chk    = 0;
    int     n_fail   = 0;
    longint ec       = 0;
    int     exp_dly2 = DD;
    bit     exp_rdy  = 1'b1;
    bit     mon_en   = 1'b0;

    // Scoreboard: enqueue accepted samples, check both taps against the queues.
    always @(negedge clk) begin
        if (mon_en) begin
            if (valid_i === 1'b1 && exp_rdy && ce === 1'b1 && flush !== 1'b1) begin
                q1.push_back('{d: data_i, due: ec + O1});
                q2.push_back('{d: data_i, due: ec + exp_dly2});
            end
            if (valid1_o === 1'b1) begin
                n_chk++;
                if (q1.size() == 0) begin
                    n_fail++;
                    $display("FAIL tap1_unexpected: valid1_o=1 data=%h, required valid1_o=0", data1_o);
                end else if (data1_o !== q1[0].d || ec != q1[0].due) begin
                    n_fail++;
                    $display("FAIL tap1_data: got %h at ec %0d, required %h at ec %0d",
                             data1_o, ec, q1[0].d, q1[0].due);
                end
                if (ce === 1'b1 && q1.size() != 0) void'(q1.pop_front());
            end else if (q1.size() != 0 && q1[0].due <= ec) begin
                n_chk++;
                n_fail++;
                $display("FAIL tap1_missing: valid1_o=%b at ec %0d, required 1 with %h",
                         valid1_o, ec, q1[0].d);
                void'(q1.pop_front());
            end
            if (valid2_o === 1'b1) begin
                n_chk++;
                if (q2.size() == 0) begin
                    n_fail++;
                    $display("FAIL tap2_unexpected: valid2_o=1 data=%h, required valid2_o=0", data2_o);
                end else if (data2_o !== q2[0].d || ec != q2[0].due) begin
                    n_fail++;
                    $display("FAIL tap2_data: got %h at ec %0d, required %h at ec %0d",
                             data2_o, ec, q2[0].d, q2[0].due);
                end
                if (ce === 1'b1 && q2.size() != 0) void'(q2.pop_front());
            end else if (q2.size() != 0 && q2[0].due <= ec) begin
                n_chk++;
                n_fail++;
                $display("FAIL tap2_missing: valid2_o=%b at ec %0d, required 1 with %h",
                         valid2_o, ec, q2[0].d);
                void'(q2.pop_front());
            end
            if (flush === 1'b1) begin
                q1.delete();
                q2.delete();
            end
            if (ce === 1'b1) ec++;
        end
    end

    function automatic logic [DW-1:0] rnd();
        return {$urandom, $urandom};
    endfunction

    // One clock cycle: drive after the rising edge, return just after the falling edge.
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic c,
                       input logic fl, input logic rq, input logic [4:0] cd);
        @(posedge clk);
        #1;
        valid_i = v; data_i = d; ce = c; flush = fl; cfg_req = rq; cfg_dly = cd;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, rnd(), 1'b1, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b0, rnd(), 1'b0, 1'b0, 1'b0, 5'd0);
        n_chk++;
        if (in_rdy_o !== 1'b1 || valid1_o !== 1'b0 || valid2_o !== 1'b0 || cfg_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_during: rdy=%b v1=%b v2=%b ack=%b, required 1 0 0 0",
                     in_rdy_o, valid1_o, valid2_o, cfg_ack_o);
        end
        rst_n = 1'b1;
        cyc(1'b0, rnd(), 1'b1, 1'b0, 1'b0, 5'd0);
        n_chk++;
        if (in_rdy_o !== 1'b1 || valid1_o !== 1'b0 || valid2_o !== 1'b0 || cfg_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_after: rdy=%b v1=%b v2=%b ack=%b, required 1 0 0 0",
                     in_rdy_o, valid1_o, valid2_o, cfg_ack_o);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_latency();
        int s1 = -1, s2 = -1, n1 = 0, n2 = 0;
        for (int c = 0; c < 16; c++) begin
            cyc(c == 0, (c == 0) ? 64'h0000_0000_0000_00A5 : rnd(), 1'b1, 1'b0, 1'b0, 5'd0);
            if (valid1_o === 1'b1) begin n1++; s1 = c; end
            if (valid2_o === 1'b1) begin n2++; s2 = c; end
        end
        n_chk++;
        if (s1 != 5 || n1 != 1) begin
            n_fail++;
            $display("FAIL latency_tap1: seen at cycle %0d count %0d, required cycle 5 count 1", s1, n1);
        end
        n_chk++;
        if (s2 != 10 || n2 != 1) begin
            n_fail++;
            $display("FAIL latency_tap2: seen at cycle %0d count %0d, required cycle 10 count 1", s2, n2);
        end
    endtask

    task automatic test_stall();
        int s2 = -1, n1 = 0, n2 = 0;
        logic [DW-1:0] d0;
        for (int c = 0; c < 16; c++) begin
            cyc(c == 0, (c == 0) ? 64'h0000_0000_0000_00A5 : rnd(), (c < 2 || c > 4), 1'b0, 1'b0, 5'd0);
            if (valid2_o === 1'b1) begin n2++; s2 = c; end
        end
        n_chk++;
        if (s2 != 13 || n2 != 1) begin
            n_fail++;
            $display("FAIL stall_tap2: seen at cycle %0d count %0d, required cycle 13 count 1", s2, n2);
        end
        d0 = rnd();
        n2 = 0;
        for (int c = 0; c < 18; c++) begin
            cyc(c == 0, (c == 0) ? d0 : rnd(), (c < 5 || c > 7), 1'b0, 1'b0, 5'd0);
            if (valid1_o === 1'b1 && data1_o === d0 && c >= 5 && c <= 8) n1++;
            if (valid2_o === 1'b1) begin n2++; s2 = c; end
        end
        n_chk++;
        if (n1 != 4) begin
            n_fail++;
            $display("FAIL stall_hold: tap1 held %0d cycles, required 4", n1);
        end
        n_chk++;
        if (s2 != 13 || n2 != 1) begin
            n_fail++;
            $display("FAIL stall_hold_tap2: seen at cycle %0d count %0d, required cycle 13 count 1", s2, n2);
        end
    endtask

    // Request a new tap-2 delay and check the drain window and the ack timing.
    task automatic do_cfg(input int cd, input bit stream, input bit hold, input bit fl);
        int cnt  = (exp_dly2 > O1) ? exp_dly2 : O1;
        int newd = (cd > MD) ? MD : cd;
        int lows = 0, acks = 0, ackc = -1;
        cyc(stream, rnd(), 1'b1, fl, 1'b1, 5'(cd));
        n_chk++;
        if (in_rdy_o !== 1'b1 || cfg_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_req_cycle: rdy=%b ack=%b, required 1 0", in_rdy_o, cfg_ack_o);
        end
        exp_rdy = 1'b0;
        for (int c = 1; c <= cnt + 4; c++) begin
            if (c == cnt + 2) begin
                exp_rdy  = 1'b1;
                exp_dly2 = newd;
            end
            cyc(stream, rnd(), 1'b1, 1'b0, hold && (c <= cnt + 2), hold ? 5'd7 : 5'd0);
            if (in_rdy_o === 1'b0) lows++;
            if (cfg_ack_o === 1'b1) begin acks++; ackc = c; end
        end
        n_chk++;
        if (lows != cnt + 1) begin
            n_fail++;
            $display("FAIL cfg_rdy_low: in_rdy_o low %0d cycles, required %0d", lows, cnt + 1);
        end
        n_chk++;
        if (acks != 1 || ackc != cnt + 2) begin
            n_fail++;
            $display("FAIL cfg_ack: %0d pulses, last at %0d, required 1 at %0d", acks, ackc, cnt + 2);
        end
    endtask

    task automatic test_reconfig();
        for (int c = 0; c < 12; c++) cyc(1'b1, rnd(), 1'b1, 1'b0, 1'b0, 5'd0);
        do_cfg(3, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 8; c++) cyc(1'b1, rnd(), 1'b1, 1'b0, 1'b0, 5'd0);
        idle(20);
        n_chk++;
        if (q1.size() != 0 || q2.size() != 0) begin
            n_fail++;
            $display("FAIL reconfig_drain: %0d/%0d samples never emerged, required 0/0", q1.size(), q2.size());
        end
    endtask

    task automatic test_zero_clamp();
        int s2 = -1, n2 = 0;
        logic [DW-1:0] d;
        do_cfg(0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            d = rnd();
            cyc(1'b1, d, 1'b1, 1'b0, 1'b0, 5'd0);
            n_chk++;
            if (valid2_o !== 1'b1 || data2_o !== d) begin
                n_fail++;
                $display("FAIL zero_passthru: v2=%b data2=%h, required 1 %h", valid2_o, data2_o, d);
            end
        end
        do_cfg(31, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 22; c++) begin
            cyc(c == 0, rnd(), 1'b1, 1'b0, 1'b0, 5'd0);
            if (valid2_o === 1'b1) begin n2++; s2 = c; end
        end
        n_chk++;
        if (s2 != 16 || n2 != 1) begin
            n_fail++;
            $display("FAIL clamp_tap2: seen at cycle %0d count %0d, required cycle 16 count 1", s2, n2);
        end
        do_cfg(10, 1'b0, 1'b0, 1'b0);
        idle(20);
        n_chk++;
        if (q1.size() != 0 || q2.size() != 0) begin
            n_fail++;
            $display("FAIL zero_clamp_drain: %0d/%0d pending, required 0/0", q1.size(), q2.size());
        end
    endtask

    task automatic test_flush();
        int n1 = 0, n2 = 0;
        cyc(1'b0, rnd(), 1'b1, 1'b0, 1'b1, 5'd4);
        exp_rdy = 1'b0;
        cyc(1'b0, rnd(), 1'b1, 1'b0, 1'b0, 5'd0);
        cyc(1'b0, rnd(), 1'b1, 1'b0, 1'b0, 5'd0);
        cyc(1'b0, rnd(), 1'b1, 1'b1, 1'b0, 5'd0);
        cyc(1'b0, rnd(), 1'b0, 1'b0, 1'b0, 5'd0);
        n_chk++;
        if (cfg_ack_o !== 1'b0 || in_rdy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_drain_apply: ack=%b rdy=%b, required 0 0", cfg_ack_o, in_rdy_o);
        end
        exp_rdy  = 1'b1;
        exp_dly2 = 4;
        cyc(1'b0, rnd(), 1'b0, 1'b0, 1'b0, 5'd0);
        n_chk++;
        if (cfg_ack_o !== 1'b1 || in_rdy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_drain_ack: ack=%b rdy=%b, required 1 1", cfg_ack_o, in_rdy_o);
        end
        cyc(1'b0, rnd(), 1'b1, 1'b0, 1'b0, 5'd0);
        n_chk++;
        if (cfg_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ack_width: ack=%b, required 0", cfg_ack_o);
        end
        do_cfg(10, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 25; c++) begin
            cyc(c <= 4, rnd(), 1'b1, c == 4, 1'b0, 5'd0);
            if (valid1_o === 1'b1) n1++;
            if (valid2_o === 1'b1) n2++;
        end
        n_chk++;
        if (n1 != 0 || n2 != 0) begin
            n_fail++;
            $display("FAIL flush_run: %0d/%0d samples emerged, required 0/0", n1, n2);
        end
        for (int c = 0; c < 4; c++) cyc(1'b1, rnd(), 1'b1, 1'b0, 1'b0, 5'd0);
        do_cfg(10, 1'b0, 1'b0, 1'b1);
        idle(20);
        n_chk++;
        if (q1.size() != 0 || q2.size() != 0) begin
            n_fail++;
            $display("FAIL flush_cfg_drain: %0d/%0d pending, required 0/0", q1.size(), q2.size());
        end
    endtask

    task automatic test_reset_drain();
        int s2 = -1, n2 = 0, acks = 0, lows = 0;
        cyc(1'b0, rnd(), 1'b1, 1'b0, 1'b1, 5'd2);
        exp_rdy = 1'b0;
        cyc(1'b0, rnd(), 1'b1, 1'b0, 1'b0, 5'd0);
        cyc(1'b0, rnd(), 1'b1, 1'b0, 1'b0, 5'd0);
        rst_n = 1'b0;
        cyc(1'b0, rnd(), 1'b1, 1'b1, 1'b1, 5'd2);
        cyc(1'b0, rnd(), 1'b1, 1'b0, 1'b0, 5'd0);
        rst_n   = 1'b1;
        exp_rdy = 1'b1;
        exp_dly2 = DD;
        for (int c = 0; c < 16; c++) begin
            cyc(c == 0, rnd(), 1'b1, 1'b0, 1'b0, 5'd0);
            if (cfg_ack_o === 1'b1) acks++;
            if (in_rdy_o !== 1'b1) lows++;
            if (valid2_o === 1'b1) begin n2++; s2 = c; end
        end
        n_chk++;
        if (acks != 0 || lows != 0) begin
            n_fail++;
            $display("FAIL reset_drain_ctl: %0d ack pulses, %0d not-ready cycles, required 0 0", acks, lows);
        end
        n_chk++;
        if (s2 != DD || n2 != 1) begin
            n_fail++;
            $display("FAIL reset_drain_dly: tap2 at cycle %0d count %0d, required cycle %0d count 1", s2, n2, DD);
        end
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b0; flush = 1'b0; valid_i = 1'b0;
        data_i = {DW{1'b0}}; cfg_req = 1'b0; cfg_dly = 5'd0;
        test_reset();
        test_latency();
        test_stall();
        test_reconfig();
        test_zero_clamp();
        test_flush();
        test_reset_drain();
        idle(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
